// File: rtl/mux_logic_unit_seq_if.sv
// Operand/result bus for the sequential mux-based logic unit.
// The master issues a start with operands and function select; the slave
// reports busy/done and the registered result with its zero flag.
interface mux_logic_unit_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             zero;

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  busy,
        input  done,
        input  y,
        input  zero
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output busy,
        output done,
        output y,
        output zero
    );
endinterface

// File: rtl/mux_logic_unit_seq.sv
// Multi-cycle bitwise logic unit. Applies one of eight two-input functions to
// WIDTH-bit operands, LANES bits per clock, LSB slice first. Every lane is a
// gate cell made only of 2:1 muxes; op picks a cell output via a mux2 tree.
module mux_logic_unit_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input logic                clk,
    input logic                rst,
    mux_logic_unit_seq_if.slave bus
);

    // Guarded so a zero LANES reports the error instead of dividing by zero.
    localparam bit ParamOk = (WIDTH >= 1) && (LANES >= 1) &&
                             ((WIDTH % ((LANES == 0) ? 1 : LANES)) == 0);
    localparam int unsigned N    = (LANES == 0) ? 1 : (WIDTH / LANES);
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    if (!ParamOk) begin : g_param_err
        $error("mux_logic_unit_seq: LANES must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;

    logic [LANES-1:0] a_slice;
    logic [LANES-1:0] b_slice;
    logic [LANES-1:0] slice_res;

    function automatic logic mux2(input logic sel, input logic d1, input logic d0);
        return sel ? d1 : d0;
    endfunction

    // One bit of the unit: every cell selects on the a bit, and ~b is itself
    // a mux2 so the whole cell stays mux-only.
    function automatic logic gate_cell(input logic [2:0] sel, input logic ab,
                                       input logic bb);
        logic nb;
        logic c_nand, c_nor, c_and, c_or, c_xor, c_xnor, c_not, c_buf;
        logic l1_0, l1_1, l1_2, l1_3;
        logic l2_0, l2_1;
        nb     = mux2(bb, 1'b0, 1'b1);
        c_nand = mux2(ab, nb, 1'b1);
        c_nor  = mux2(ab, 1'b0, nb);
        c_and  = mux2(ab, bb, 1'b0);
        c_or   = mux2(ab, 1'b1, bb);
        c_xor  = mux2(ab, nb, bb);
        c_xnor = mux2(ab, bb, nb);
        c_not  = mux2(ab, 1'b0, 1'b1);
        c_buf  = mux2(ab, 1'b1, 1'b0);
        // Three-level select tree: op[0], then op[1], then op[2].
        l1_0 = mux2(sel[0], c_nor, c_nand);
        l1_1 = mux2(sel[0], c_or, c_and);
        l1_2 = mux2(sel[0], c_xnor, c_xor);
        l1_3 = mux2(sel[0], c_buf, c_not);
        l2_0 = mux2(sel[1], l1_1, l1_0);
        l2_1 = mux2(sel[1], l1_3, l1_2);
        return mux2(sel[2], l2_1, l2_0);
    endfunction

    // Pick the operand slice addressed by the counter (constant slice bounds).
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned s = 0; s < N; s++) begin
            if (cnt_q == CntW'(s)) begin
                a_slice = a_q[s*LANES +: LANES];
                b_slice = b_q[s*LANES +: LANES];
            end
        end
    end

    // Gate cells, one per lane.
    always_comb begin
        slice_res = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            slice_res[i] = gate_cell(op_q, a_slice[i], b_slice[i]);
        end
    end

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        y_d     = y_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int unsigned s = 0; s < N; s++) begin
                    if (cnt_q == CntW'(s)) begin
                        acc_d[s*LANES +: LANES] = slice_res;
                    end
                end
                if (cnt_q == CntLast) begin
                    // acc_d already holds the final slice, so publish it now.
                    y_d     = acc_d;
                    zero_d  = (acc_d == '0);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
        end
    end

    // Status decoded from registered state only.
    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = (state_q == StDone);
        bus.y    = y_q;
        bus.zero = zero_q;
    end

endmodule

// File: tb/tb_mux_logic_unit_seq.sv
// Bench for mux_logic_unit_seq: three instances (8/1, 8/4, 4/4), a vector
// table, a per-instance expected-result queue checked on every done pulse,
// and hand-written sequences for ignored start and mid-run reset.
module tb_mux_logic_unit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_r;
    logic [2:0] op_r;
    logic [7:0] a_r;
    logic [7:0] b_r;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_logic_unit_seq_if #(.WIDTH(8)) if0 ();
    mux_logic_unit_seq_if #(.WIDTH(8)) if1 ();
    mux_logic_unit_seq_if #(.WIDTH(4)) if2 ();

    assign if0.start = start_r[0];
    assign if0.op    = op_r;
    assign if0.a     = a_r;
    assign if0.b     = b_r;
    assign if1.start = start_r[1];
    assign if1.op    = op_r;
    assign if1.a     = a_r;
    assign if1.b     = b_r;
    assign if2.start = start_r[2];
    assign if2.op    = op_r;
    assign if2.a     = a_r[3:0];
    assign if2.b     = b_r[3:0];

    mux_logic_unit_seq #(.WIDTH(8), .LANES(1)) u_w8l1 (.clk(clk), .rst(rst), .bus(if0));
    mux_logic_unit_seq #(.WIDTH(8), .LANES(4)) u_w8l4 (.clk(clk), .rst(rst), .bus(if1));
    mux_logic_unit_seq #(.WIDTH(4), .LANES(4)) u_w4l4 (.clk(clk), .rst(rst), .bus(if2));

    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] zero_v;
    logic [7:0] y_v [3];

    assign busy_v = {if2.busy, if1.busy, if0.busy};
    assign done_v = {if2.done, if1.done, if0.done};
    assign zero_v = {if2.zero, if1.zero, if0.zero};
    assign y_v[0] = if0.y;
    assign y_v[1] = if1.y;
    assign y_v[2] = {4'h0, if2.y};

    // Scoreboard entries: {zero, y}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    typedef struct {
        int         s;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int s, input logic [7:0] y);
        logic [8:0] e;
        e = {(y == 8'h00), y};
        case (s)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int s, output bit have, output logic [8:0] e);
        have = 1'b0;
        e    = '0;
        case (s)
            0:       if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
            1:       if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
            default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
        endcase
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 3; s++) begin
                if (done_v[s]) begin
                    bit         have;
                    logic [8:0] e;
                    pop_exp(s, have, e);
                    check($sformatf("done_expected[%0d]", s), 32'(have), 32'd1);
                    if (have) begin
                        check($sformatf("y[%0d]", s), 32'(y_v[s]), 32'(e[7:0]));
                        check($sformatf("zero[%0d]", s), 32'(zero_v[s]), 32'(e[8]));
                    end
                end
            end
        end
    end

    // Launch one operation on instance s and time busy/done. inject_at >= 0
    // pulses a second start (with a changed) during RUN.
    task automatic run_op(input int s, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_y,
                          input int inject_at);
        int n;
        int busy_cnt;
        bit seen;
        n = (s == 0) ? 8 : ((s == 1) ? 2 : 1);
        push_exp(s, exp_y);
        op_r    = op;
        a_r     = a;
        b_r     = b;
        start_r = 3'(1 << s);
        @(posedge clk);
        @(negedge clk);
        start_r  = '0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i == inject_at) begin
                a_r     = 8'h00;
                start_r = 3'(1 << s);
            end else begin
                start_r = '0;
            end
            if (busy_v[s]) busy_cnt++;
            else if (done_v[s]) seen = 1'b1;
            if (!seen) @(negedge clk);
        end
        start_r = '0;
        check($sformatf("busy_cycles[%0d] op%0d", s, op), 32'(busy_cnt), 32'(n));
        check($sformatf("done_seen[%0d] op%0d", s, op), 32'(seen), 32'd1);
        @(negedge clk);
        check($sformatf("done_single[%0d] op%0d", s, op), 32'(done_v[s]), 32'd0);
        check($sformatf("idle_after[%0d] op%0d", s, op), 32'(busy_v[s]), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        tbl[0]  = '{0, 3'd0, 8'hF0, 8'hCC, 8'h3F};
        tbl[1]  = '{0, 3'd1, 8'hF0, 8'hCC, 8'h03};
        tbl[2]  = '{0, 3'd2, 8'hF0, 8'hCC, 8'hC0};
        tbl[3]  = '{0, 3'd3, 8'hF0, 8'hCC, 8'hFC};
        tbl[4]  = '{0, 3'd4, 8'hF0, 8'hCC, 8'h3C};
        tbl[5]  = '{0, 3'd5, 8'hF0, 8'hCC, 8'hC3};
        tbl[6]  = '{0, 3'd6, 8'hF0, 8'hCC, 8'h0F};
        tbl[7]  = '{0, 3'd7, 8'hF0, 8'hCC, 8'hF0};
        tbl[8]  = '{0, 3'd2, 8'h0F, 8'hF0, 8'h00};
        tbl[9]  = '{0, 3'd5, 8'h5A, 8'h5A, 8'hFF};
        tbl[10] = '{1, 3'd5, 8'hA5, 8'h5A, 8'h00};
        tbl[11] = '{1, 3'd4, 8'hA5, 8'h5A, 8'hFF};
        tbl[12] = '{1, 3'd0, 8'hFF, 8'h0F, 8'hF0};
        tbl[13] = '{2, 3'd3, 8'h09, 8'h06, 8'h0F};
        tbl[14] = '{2, 3'd7, 8'h0A, 8'h05, 8'h0A};
        tbl[15] = '{2, 3'd1, 8'h0A, 8'h05, 8'h00};

        rst     = 1'b1;
        start_r = '0;
        op_r    = '0;
        a_r     = '0;
        b_r     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_busy[%0d]", s), 32'(busy_v[s]), 32'd0);
            check($sformatf("rst_done[%0d]", s), 32'(done_v[s]), 32'd0);
            check($sformatf("rst_y[%0d]", s), 32'(y_v[s]), 32'd0);
            check($sformatf("rst_zero[%0d]", s), 32'(zero_v[s]), 32'd1);
        end

        foreach (tbl[i]) begin
            run_op(tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, -1);
        end

        // Second start with a changed operand at edge k+3 must be ignored.
        run_op(0, 3'd0, 8'hF0, 8'hCC, 8'h3F, 2);
        check("y_hold_after_ignored_start", 32'(y_v[0]), 32'h3F);

        // Reset at edge k+4 aborts the run; no done afterwards.
        op_r    = 3'd0;
        a_r     = 8'hF0;
        b_r     = 8'hCC;
        start_r = 3'b001;
        @(posedge clk);
        @(negedge clk);
        start_r = '0;
        check("abort_busy_running", 32'(busy_v[0]), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_done", 32'(done_v[0]), 32'd0);
        check("abort_y", 32'(y_v[0]), 32'd0);
        check("abort_zero", 32'(zero_v[0]), 32'd1);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_queue_empty", 32'(q0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
